// File: rtl/pipe_sub_pkg.sv
// Shared constants for the bit-serial pipelined subtractor.
package pipe_sub_pkg;

  localparam int PIPE_SUB_WIDTH  = 4;
  localparam int PIPE_SUB_STAGES = PIPE_SUB_WIDTH + 1;

  // Number of bit-resolving register stages (stage 0 plus one per bit).
  function automatic int pipe_sub_stages(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/pipeline_subtractor.sv
// Pipelined ripple subtractor: stage 0 captures the operands, stage k resolves
// bit k-1, and a final output register presents diff/bout/ovf to the consumer.
// Every stage carries a valid bit; the whole pipe advances only when the output
// register is empty or being consumed.
// Optional feature: define PIPE_SUB_OVF_EN to enable the signed-overflow flag.
module pipeline_subtractor
  import pipe_sub_pkg::*;
#(
  parameter int WIDTH = PIPE_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NSTG = pipe_sub_stages(WIDTH);

  // Stage registers: operands shift right as their low bit is consumed, the
  // partial difference fills in one bit per stage, br carries the borrow.
  logic [NSTG-1:0]  v_q,  v_d;
  logic [NSTG-1:0]  br_q, br_d;
  logic [WIDTH-1:0] a_q [WIDTH];
  logic [WIDTH-1:0] a_d [WIDTH];
  logic [WIDTH-1:0] b_q [WIDTH];
  logic [WIDTH-1:0] b_d [WIDTH];
  logic [WIDTH-1:0] d_q [NSTG];
  logic [WIDTH-1:0] d_d [NSTG];

  logic [WIDTH-1:0] fs_d;
  logic [WIDTH-1:0] fs_b;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic advance;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // One full subtractor per bit stage, fed by the previous stage's low bits.
  for (genvar k = 1; k <= WIDTH; k++) begin : g_bit
    full_subtractor u_fs (
      .a    (a_q[k-1][0]),
      .b    (b_q[k-1][0]),
      .bin  (br_q[k-1]),
      .d    (fs_d[k-1]),
      .bout (fs_b[k-1])
    );
  end

  // Next-state for all stages: hold by default, shift one stage on advance.
  always_comb begin
    v_d         = v_q;
    br_d        = br_q;
    a_d         = a_q;
    b_d         = b_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    if (advance) begin
      v_d[0] = in_valid;
      d_d[0] = '0;
      if (in_valid) begin
        a_d[0]  = a;
        b_d[0]  = b;
        br_d[0] = bin;
      end
      for (int k = 1; k <= WIDTH; k++) begin
        v_d[k]       = v_q[k-1];
        br_d[k]      = fs_b[k-1];
        d_d[k]       = d_q[k-1];
        d_d[k][k-1]  = fs_d[k-1];
      end
      for (int k = 1; k < WIDTH; k++) begin
        a_d[k] = a_q[k-1] >> 1;
        b_d[k] = b_q[k-1] >> 1;
      end
      out_valid_d = v_q[WIDTH];
      diff_d      = d_q[WIDTH];
      bout_d      = br_q[WIDTH];
    end
  end

  // Stage and output registers; reset drops every in-flight entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      br_q        <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k < NSTG; k++) begin
        d_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
    end else begin
      v_q         <= v_d;
      br_q        <= br_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

`ifdef PIPE_SUB_OVF_EN
  // Operand sign bits travel alongside the data so the overflow flag lines up
  // with the finished difference.
  logic [NSTG-1:0] sa_q, sa_d;
  logic [NSTG-1:0] sb_q, sb_d;
  logic            ovf_q, ovf_d;

  // Sign-bit pipeline and overflow next-state, gated by the same advance.
  always_comb begin
    sa_d  = sa_q;
    sb_d  = sb_q;
    ovf_d = ovf_q;
    if (advance) begin
      if (in_valid) begin
        sa_d[0] = a[WIDTH-1];
        sb_d[0] = b[WIDTH-1];
      end
      for (int k = 1; k <= WIDTH; k++) begin
        sa_d[k] = sa_q[k-1];
        sb_d[k] = sb_q[k-1];
      end
      ovf_d = (sa_q[WIDTH] != sb_q[WIDTH]) && (d_q[WIDTH][WIDTH-1] != sa_q[WIDTH]);
    end
  end

  // Overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q  <= '0;
      sb_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_subtractor.sv
// Self-checking bench for pipeline_subtractor (WIDTH = 4).
// Honours PIPE_SUB_OVF_EN when deciding the expected ovf value.
module tb_pipeline_subtractor;

  localparam int W = 4;
`ifdef PIPE_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         out_valid;
  logic         out_ready = 1'b1;

  pipeline_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;   // value when the overflow feature is built in
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  vec_t vecs[9];
  vec_t strm[4];

  // Reference: plain integer subtraction, overflow from the sign rule.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    res_t r;
    int   full;
    full = int'(ma) - int'(mb) - int'(mbin);
    r.d  = W'(full);
    r.bo = (full < 0);
    r.ov = OVF_EN && (ma[W-1] != mb[W-1]) && (r.d[W-1] != ma[W-1]);
    return r;
  endfunction

  // Scoreboard for the randomized phase, sampled on the falling edge.
  res_t         q_exp[$];
  bit           mon_en = 1'b0;
  bit           hold_pend = 1'b0;
  logic [31:0]  hold_val;
  int           n_in = 0;
  int           n_out = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_pend)
        chk("stall_hold", {25'd0, out_valid, diff, bout, ovf}, hold_val);
      hold_pend = out_valid && !out_ready;
      hold_val  = {25'd0, out_valid, diff, bout, ovf};
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          chk("spurious_output", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = q_exp.pop_front();
          chk("rand_result", {26'd0, diff, bout, ovf}, {26'd0, e.d, e.bo, e.ov});
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        q_exp.push_back(model(a, b, bin));
        n_in++;
      end
    end
  end

  // Single operation: call at #1 after an edge; checks exact latency W+1 and
  // that nothing appears at the output before it.
  task automatic run_vec(input vec_t v);
    logic early;
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("accept_ready", {31'd0, in_ready}, 32'd1);
    early = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    early |= out_valid;
    repeat (W) begin
      @(posedge clk); #1;
      early |= out_valid;
    end
    chk("no_early_valid", {31'd0, early}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("vec_diff", {28'd0, diff}, {28'd0, v.d});
    chk("vec_bout", {31'd0, bout}, {31'd0, v.bo});
    chk("vec_ovf", {31'd0, ovf}, {31'd0, v.ov & OVF_EN});
  endtask

  // Back-to-back stream of four, optionally stalling the first result 3 cycles.
  task automatic run_stream(input bit stall);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      a = strm[j].a; b = strm[j].b; bin = strm[j].bin; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    if (stall) begin
      out_ready = 1'b0;
      #1 chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (3) begin
        @(posedge clk); #1;
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_diff", {28'd0, diff}, {28'd0, strm[0].d});
      end
      out_ready = 1'b1;
      #1 chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    end
    for (int j = 0; j < 4; j++) begin
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_diff", {28'd0, diff}, {28'd0, strm[j].d});
      chk("stream_bout", {31'd0, bout}, {31'd0, strm[j].bo});
      chk("stream_ovf", {31'd0, ovf}, {31'd0, strm[j].ov & OVF_EN});
      @(posedge clk); #1;
    end
    chk("stream_drained", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1};
    vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[4] = '{4'h0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[5] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    vecs[6] = '{4'h5, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0};
    vecs[7] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b1, 1'b1};
    vecs[8] = '{4'h6, 4'h2, 1'b1, 4'h3, 1'b0, 1'b0};
    strm[0] = vecs[0];
    strm[1] = vecs[1];
    strm[2] = vecs[3];
    strm[3] = vecs[4];

    // Reset values while rst is held.
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {28'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // First edge after release must accept.
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(vecs[0]);

    for (int i = 1; i < 9; i++) begin
      @(posedge clk); #1;
      run_vec(vecs[i]);
    end

    run_stream(1'b0);
    run_stream(1'b1);

    // Reset with three operations in flight.
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      a = strm[j].a; b = strm[j].b; bin = strm[j].bin; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(vecs[0]);

    // Randomized traffic with random back-pressure.
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (600) begin
      a         = W'($urandom);
      b         = W'($urandom);
      bin       = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3 * W + 4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("rand_queue_empty", q_exp.size(), 32'd0);
    chk("rand_count", n_out, n_in);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_subtractor.md
PIPELINE_SUBTRACTOR -- requirements
Module: pipeline_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: a  input  WIDTH  minuend.
REQ-005 SHALL have port: b  input  WIDTH  subtrahend.
REQ-006 SHALL have port: bin  input  1  borrow-in.
REQ-007 SHALL have port: in_valid  input  1  a/b/bin valid.
REQ-008 SHALL have port: in_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have port: diff  output  WIDTH  registered difference.
REQ-010 SHALL have port: bout  output  1  registered borrow-out.
REQ-011 SHALL have port: ovf  output  1  registered signed overflow (see Configuration).
REQ-012 SHALL have port: out_valid  output  1  diff/bout/ovf valid.
REQ-013 SHALL have port: out_ready  input  1  consumer accepts output this cycle.

Function
REQ-014 SHALL compute diff = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin (unsigned).
REQ-015 SHALL be a WIDTH+1 stage pipeline: stage 0 registers a, b, bin; stage k (1..WIDTH) resolves bit k-1 via one full subtractor and registers partial diff, borrow, remaining operand bits.
REQ-016 SHALL carry a valid bit per stage; bubbles propagate as invalid entries.
REQ-017 SHALL define advance = !out_valid || out_ready; all stages shift only when advance = 1.
REQ-018 SHALL drive in_ready = advance combinationally; transfer in occurs when in_valid && in_ready at a rising edge.
REQ-019 SHALL give latency WIDTH+1 cycles: input accepted at edge N appears with out_valid = 1 after edge N+WIDTH+1, absent stalls.
REQ-020 SHALL sustain one result per cycle when in_valid and out_ready are held high.
REQ-021 SHALL hold diff, bout, ovf, out_valid and all stage contents stable while out_valid && !out_ready.
REQ-022 SHALL load an invalid entry into stage 0 when advance = 1 and in_valid = 0.
REQ-023 SHALL, on simultaneous output consume and input accept, perform both in the same edge without loss or duplication.
REQ-024 SHALL ignore a, b, bin when in_valid = 0 or in_ready = 0.

Reset
REQ-025 SHALL, while rst = 1, clear all stage valid bits and data registers; diff = 0, bout = 0, ovf = 0, out_valid = 0, in_ready = 1.
REQ-026 SHALL discard all in-flight operations on reset asserted mid-stream; no result emerges after release for pre-reset inputs.
REQ-027 SHALL accept input on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro PIPE_SUB_OVF_EN defined, drive ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), pipelined aligned with diff.
REQ-029 SHALL, without PIPE_SUB_OVF_EN, tie ovf to 0 and instantiate no overflow pipeline registers.

Structure
REQ-030 SHALL place default WIDTH constant and stage-count constant (WIDTH+1) in shared package pipe_sub_pkg.
REQ-031 SHALL use one sub-module, full_subtractor (a, b, bin -> d, bout), instantiated once per bit stage.

Verification
REQ-032 a=9, b=3, bin=0, out_ready=1 -> diff=6, bout=0, out_valid high exactly 5 cycles after accept (WIDTH=4).
REQ-033 a=3, b=9, bin=0 -> diff=0xA, bout=1; a=0, b=0, bin=1 -> diff=0xF, bout=1.
REQ-034 Stream (9,3),(3,9),(0xF,0xF),(0,1) on consecutive cycles, out_ready=1 -> results 6/0, A/1, 0/0, F/1 on consecutive cycles, in order.
REQ-035 Same stream with out_ready=0 for 3 cycles once first result valid -> outputs held, in_ready=0 during stall, no result lost or repeated.
REQ-036 a=8, b=1 -> diff=7, ovf=1 with PIPE_SUB_OVF_EN, ovf=0 without; a=5, b=2 -> ovf=0 both builds.
REQ-037 Assert rst with 3 entries in flight -> out_valid=0 immediately, no stale results after release, next accepted (9,3) yields 6.
